// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud divisor helper
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int divisor(input int frequency, input int baudrate, input int oversample);
    return frequency / (baudrate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - received-word handshake bus between receiver and consumer
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (output data, output valid, output parity_err, output frame_err, input ready);
  modport slave  (input data, input valid, input parity_err, input frame_err, output ready);
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchronizer, tick divider and bit sampler
// UART_RX_MAJORITY_EN selects a three-sample vote around mid-bit, else one sample at mid-bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int FREQUENCY  = 1_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic run,
  output logic rx_sync,
  output logic fall,
  output logic bit_valid,
  output logic bit_value
);
  localparam int DIV = divisor(FREQUENCY, BAUDRATE, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] M_LO     = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] M_MID    = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] M_HI     = TW'(OVERSAMPLE / 2 + 1);

  logic          rx_meta;
  logic          rx_prev;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          samp_mid;
`ifdef UART_RX_MAJORITY_EN
  logic          samp_lo;
`endif

  assign tick      = run && (div_cnt == DIV_LAST);
  assign fall      = rx_prev && !rx_sync;
  // The decision is made on the M+1 tick itself so the FSM can act in that same cycle.
  assign bit_valid = tick && (tick_cnt == M_HI);
`ifdef UART_RX_MAJORITY_EN
  assign bit_value = (samp_lo & samp_mid) | (samp_lo & rx_sync) | (samp_mid & rx_sync);
`else
  assign bit_value = samp_mid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      div_cnt  <= '0;
      tick_cnt <= '0;
      samp_mid <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      samp_lo  <= 1'b1;
`endif
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (!run) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        div_cnt  <= '0;
        tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == M_MID) samp_mid <= rx_sync;
`ifdef UART_RX_MAJORITY_EN
        if (tick_cnt == M_LO) samp_lo <= rx_sync;
`endif
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver: frame FSM and output register
// Sampling mode is chosen in uart_rx_sampler by UART_RX_MAJORITY_EN.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int FREQUENCY  = 1_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  uart_rx_cfg_if.master word_bus,
  output logic overrun,
  output logic break_det,
  output logic busy
);
  localparam int DIV = divisor(FREQUENCY, BAUDRATE, OVERSAMPLE);
  localparam int CW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam parity_e       PAR_MODE  = parity_e'(PARITY);

  if (DIV < 1 || !(OVERSAMPLE == 8 || OVERSAMPLE == 16) || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || !(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_params
    $error("uart_rx_cfg: illegal parameter combination");
  end

  rx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 par;
  logic                 all_zero;
  logic                 perr_acc;
  logic                 ferr_acc;
  logic                 rx_sync;
  logic                 fall;
  logic                 bit_valid;
  logic                 bit_value;

  uart_rx_sampler #(
    .FREQUENCY (FREQUENCY),
    .BAUDRATE  (BAUDRATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .run      (busy),
    .rx_sync  (rx_sync),
    .fall     (fall),
    .bit_valid(bit_valid),
    .bit_value(bit_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      busy                <= 1'b0;
      shreg               <= '0;
      bit_cnt             <= '0;
      stop_cnt            <= 1'b0;
      par                 <= 1'b0;
      all_zero            <= 1'b0;
      perr_acc            <= 1'b0;
      ferr_acc            <= 1'b0;
      word_bus.data       <= '0;
      word_bus.valid      <= 1'b0;
      word_bus.parity_err <= 1'b0;
      word_bus.frame_err  <= 1'b0;
      overrun             <= 1'b0;
      break_det           <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      if (word_bus.valid && word_bus.ready) word_bus.valid <= 1'b0;
      case (state)
        IDLE: if (fall) begin
          state <= START;
          busy  <= 1'b1;
        end
        START: if (bit_valid) begin
          if (!bit_value) begin
            state    <= DATA;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            all_zero <= 1'b1;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: if (bit_valid) begin
          shreg    <= {bit_value, shreg[DATA_BITS-1:1]};
          par      <= par ^ bit_value;
          all_zero <= all_zero & ~bit_value;
          if (bit_cnt == BIT_LAST) state <= (PAR_MODE == NONE) ? STOP : uart_pkg::PARITY;
          else                     bit_cnt <= bit_cnt + 1'b1;
        end
        uart_pkg::PARITY: if (bit_valid) begin
          perr_acc <= bit_value ^ par ^ (PAR_MODE == ODD);
          all_zero <= all_zero & ~bit_value;
          state    <= STOP;
        end
        STOP: if (bit_valid) begin
          if (!stop_cnt && all_zero && !bit_value) begin
            state     <= BREAK;
            break_det <= 1'b1;
          end else if (stop_cnt == STOP_LAST) begin
            // Return to IDLE mid stop bit so a back-to-back start edge is not missed.
            state <= IDLE;
            busy  <= 1'b0;
            if (!word_bus.valid || word_bus.ready) begin
              word_bus.data       <= shreg;
              word_bus.valid      <= 1'b1;
              word_bus.parity_err <= perr_acc;
              word_bus.frame_err  <= ferr_acc | ~bit_value;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            stop_cnt <= 1'b1;
            ferr_acc <= ferr_acc | ~bit_value;
          end
        end
        BREAK: if (rx_sync) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
